display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler.sv | 91 +++++++++
 tb/tb_display_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates the LCD between memory/accumulator views (round-robin,
// fixed dwell per grant) and a loading banner that preempts everything.
module display_scheduler #(
    parameter logic [23:0] DWELL = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] mem_data,
    input  logic [15:0] acc_data,
    output logic [15:0] dsply,
    output logic        dsply_en,
    output logic        lcd_en,
    output logic [2:0]  grant,
    output logic [1:0]  ack
);
    typedef enum logic [1:0] {IDLE, SHOW, RELEASE, LOAD} state_t;
    localparam logic [23:0] DWELL_M1 = (DWELL == 24'd0) ? 24'd0 : DWELL - 24'd1;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [23:0] cnt_q, cnt_d;
    logic [15:0] dsply_q, dsply_d;
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  grant_q, grant_d;
    logic [1:0]  ack_q, ack_d;
    logic        own, eff_ptr, any, win;

    assign own     = grant_q[1];
    // in RELEASE the pointer has not been written yet, so arbitrate with its next value
    assign eff_ptr = (state_q == RELEASE) ? ~own : ptr_q;
    assign any     = req[0] | req[1];
    assign win     = (req[0] & req[1]) ? eff_ptr : req[1];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dsply_d = dsply_q;
        mode_d  = mode_q;
        grant_d = grant_q;
        ack_d   = 2'b00;
        if (req[2]) begin
            state_d = LOAD;
            grant_d = 3'b100;
            mode_d  = 2'b11;
            cnt_d   = 24'd0;
        end else if (state_q == LOAD) begin
            state_d = IDLE;
            grant_d = 3'b000;
            mode_d  = 2'b00;
        end else if (state_q == SHOW) begin
            state_d = (cnt_q == 24'd0) ? RELEASE : SHOW;
            ack_d   = (cnt_q == 24'd0) ? (own ? 2'b10 : 2'b01) : 2'b00;
            cnt_d   = (cnt_q == 24'd0) ? cnt_q : cnt_q - 24'd1;
        end else begin
            ptr_d   = (state_q == RELEASE) ? ~own : ptr_q;
            state_d = any ? SHOW : IDLE;
            grant_d = any ? (win ? 3'b010 : 3'b001) : 3'b000;
            mode_d  = any ? (win ? 2'b10 : 2'b01) : 2'b00;
            dsply_d = any ? (win ? acc_data : mem_data) : dsply_q;
            cnt_d   = any ? DWELL_M1 : 24'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 24'd0;
            dsply_q <= 16'h0000;
            mode_q  <= 2'b00;
            grant_q <= 3'b000;
            ack_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dsply_q <= dsply_d;
            mode_q  <= mode_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
        end
    end

    assign dsply    = dsply_q;
    assign dsply_en = mode_q[1];
    assign lcd_en   = mode_q[0];
    assign grant    = grant_q;
    assign ack      = ack_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed scenarios; expected output runs {grant,mode,dsply,ack,length}
// are queued by the stimulus and matched by per-DUT monitors as each run ends.
module tb_display_scheduler;
    typedef struct {
        logic [22:0] t;
        int          len;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [15:0] mem_data = 16'h0000, acc_data = 16'h0000;
    logic        zen = 1'b1, mon_on = 1'b0;
    logic [2:0]  req_z;
    logic [15:0] dsply4, dsply0;
    logic        den4, len4, den0, len0e;
    logic [2:0]  grant4, grant0;
    logic [1:0]  ack4, ack0;
    logic [22:0] tup4, tup0;
    int          errors = 0, checks = 0;
    ev_t         q4[$], q0[$];

    assign req_z = zen ? req : 3'b000;
    assign tup4  = {grant4, den4, len4, dsply4, ack4};
    assign tup0  = {grant0, den0, len0e, dsply0, ack0};

    always #5 clk = ~clk;

    display_scheduler #(.DWELL(24'd4)) u_dut (
        .clk(clk), .reset(reset), .req(req), .mem_data(mem_data), .acc_data(acc_data),
        .dsply(dsply4), .dsply_en(den4), .lcd_en(len4), .grant(grant4), .ack(ack4)
    );

    display_scheduler #(.DWELL(24'd0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_z), .mem_data(mem_data), .acc_data(acc_data),
        .dsply(dsply0), .dsply_en(den0), .lcd_en(len0e), .grant(grant0), .ack(ack0)
    );

    function automatic ev_t ev(logic [2:0] g, logic [1:0] m, logic [15:0] d, logic [1:0] a, int n);
        ev_t e;
        e.t   = {g, m, d, a};
        e.len = n;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_ev(input string nm, input logic [22:0] t, input int n, input ev_t e);
        checks++;
        if (e.len < 0 || t !== e.t || (e.len > 0 && n != e.len)) begin
            errors++;
            $display("FAIL %s run: got {g,m,d,a}=%h len=%0d expected %h len=%0d", nm, t, n, e.t, e.len);
        end
    endtask

    logic [22:0] cur4, cur0;
    int          n4, n0;
    bit          have4 = 0, have0 = 0;
    ev_t         e4, e0;

    // a run of identical output cycles is compared once it ends
    always @(negedge clk) begin
        if (!mon_on) have4 = 0;
        else if (!have4) begin cur4 = tup4; n4 = 1; have4 = 1; end
        else if (tup4 == cur4) n4++;
        else begin
            e4 = '{t: 23'h0, len: -1};
            if (q4.size() != 0) e4 = q4.pop_front();
            chk_ev("dwell4", cur4, n4, e4);
            cur4 = tup4;
            n4 = 1;
        end
    end

    always @(negedge clk) begin
        if (!mon_on) have0 = 0;
        else if (!have0) begin cur0 = tup0; n0 = 1; have0 = 1; end
        else if (tup0 == cur0) n0++;
        else begin
            e0 = '{t: 23'h0, len: -1};
            if (q0.size() != 0) e0 = q0.pop_front();
            chk_ev("dwell0", cur0, n0, e0);
            cur0 = tup0;
            n0 = 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        step(2);
        chk("reset_dwell4", {9'd0, tup4}, 32'd0);
        chk("reset_dwell0", {9'd0, tup0}, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        mon_on = 1'b1;
        // memory view alone; the DWELL=0 instance sees the same request
        q4.push_back(ev(3'b000, 2'b00, 16'h0000, 2'b00, 0));
        q4.push_back(ev(3'b001, 2'b01, 16'h12AB, 2'b00, 4));
        q4.push_back(ev(3'b001, 2'b01, 16'h12AB, 2'b01, 1));
        q0.push_back(ev(3'b000, 2'b00, 16'h0000, 2'b00, 0));
        q0.push_back(ev(3'b001, 2'b01, 16'h12AB, 2'b00, 1));
        q0.push_back(ev(3'b001, 2'b01, 16'h12AB, 2'b01, 1));
        step(2);
        mem_data = 16'h12AB;
        req = 3'b001;
        step(1);
        req = 3'b000;
        zen = 1'b0;
        step(8);
        // accumulator held with data changing mid-dwell
        q4.push_back(ev(3'b000, 2'b00, 16'h12AB, 2'b00, 0));
        q4.push_back(ev(3'b010, 2'b10, 16'h0005, 2'b00, 4));
        q4.push_back(ev(3'b010, 2'b10, 16'h0005, 2'b10, 1));
        q4.push_back(ev(3'b010, 2'b10, 16'h0007, 2'b00, 4));
        q4.push_back(ev(3'b010, 2'b10, 16'h0007, 2'b10, 1));
        acc_data = 16'h0005;
        req = 3'b010;
        step(2);
        acc_data = 16'h0007;
        step(5);
        req = 3'b000;
        step(6);
        // banner preempts the 2nd dwell cycle, memory view re-granted afterwards
        q4.push_back(ev(3'b000, 2'b00, 16'h0007, 2'b00, 0));
        q4.push_back(ev(3'b001, 2'b01, 16'h3C3C, 2'b00, 2));
        q4.push_back(ev(3'b100, 2'b11, 16'h3C3C, 2'b00, 1));
        q4.push_back(ev(3'b000, 2'b00, 16'h3C3C, 2'b00, 1));
        q4.push_back(ev(3'b001, 2'b01, 16'h4D4D, 2'b00, 4));
        q4.push_back(ev(3'b001, 2'b01, 16'h4D4D, 2'b01, 1));
        q4.push_back(ev(3'b000, 2'b00, 16'h4D4D, 2'b00, 0));
        mem_data = 16'h3C3C;
        req = 3'b001;
        step(2);
        req = 3'b101;
        step(1);
        req = 3'b001;
        mem_data = 16'h4D4D;
        step(2);
        req = 3'b000;
        step(7);
        // asynchronous reset in the middle of a dwell
        mem_data = 16'h5555;
        req = 3'b001;
        step(2);
        #2;
        mon_on = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_reset_dwell4", {9'd0, tup4}, 32'd0);
        chk("async_reset_dwell0", {9'd0, tup0}, 32'd0);
        chk("pending_before_reset4", q4.size(), 32'd0);
        chk("pending_before_reset0", q0.size(), 32'd0);
        mem_data = 16'hAAAA;
        acc_data = 16'hBBBB;
        req = 3'b011;
        q4.push_back(ev(3'b001, 2'b01, 16'hAAAA, 2'b00, 4));
        q4.push_back(ev(3'b001, 2'b01, 16'hAAAA, 2'b01, 1));
        q4.push_back(ev(3'b010, 2'b10, 16'hBBBB, 2'b00, 4));
        q4.push_back(ev(3'b010, 2'b10, 16'hBBBB, 2'b10, 1));
        q4.push_back(ev(3'b001, 2'b01, 16'hAAAA, 2'b00, 4));
        q4.push_back(ev(3'b001, 2'b01, 16'hAAAA, 2'b01, 1));
        @(negedge clk);
        #1;
        reset = 1'b1;
        mon_on = 1'b1;
        step(12);
        req = 3'b000;
        step(6);
        chk("pending_end4", q4.size(), 32'd0);
        chk("pending_end0", q0.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
